// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and buffer state encoding for the fifo_rd_stream read-side adapter.
package fifo_rd_stream_pkg;

  localparam int unsigned BUF_DEPTH          = 2;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_rd_buf2.sv
// Two-entry register buffer; slot0 is always the head so the output data is a plain flop.
module fifo_rd_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               push_i,
  input  logic [DATA_WIDTH-1:0]              push_data_i,
  input  logic                               pop_i,
  output logic [DATA_WIDTH-1:0]              head_o,
  output logic                               valid_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     count_o
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_i) begin
          slot0_d = push_data_i;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        // Push and pop together: the new word goes straight to the head, no bubble.
        if (push_i && pop_i) begin
          slot0_d = push_data_i;
        end else if (push_i) begin
          slot1_d = push_data_i;
          state_d = ST_TWO;
        end else if (pop_i) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop_i) begin
          slot0_d = slot1_q;
          if (push_i) begin
            slot1_d = push_data_i;
          end else begin
            state_d = ST_ONE;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign head_o  = slot0_q;
  assign valid_o = (state_q != ST_EMPTY);
  assign count_o = state_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && (state_q == ST_TWO) && !pop_i));

endmodule

// File: rtl/fifo_rd_stream.sv
// async_fifo read side to valid/ready stream adapter with a 2-entry output buffer.
// Optional statistics counters enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic       inflight_q;
  logic [1:0] count;
  logic [2:0] used;
  logic       pop;

  assign pop  = m_valid & m_ready;
  assign used = {1'b0, count} + {2'b00, inflight_q};

  // m_ready reaches fifo_rd_en combinationally so a full buffer can refill on a pop.
  assign fifo_rd_en = !rd_rst && !fifo_empty &&
                      ((used < 3'd2) || ((used == 3'd2) && pop));

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
    end
  end

  fifo_rd_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i      (rd_clk),
    .rst_i      (rd_rst),
    .push_i     (inflight_q),
    .push_data_i(fifo_rd_data),
    .pop_i      (pop),
    .head_o     (m_data),
    .valid_o    (m_valid),
    .count_o    (count)
  );

`ifdef FIFO_RD_STATS_EN
  logic [CNT_WIDTH-1:0] beat_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (m_valid && !m_ready) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: vector table for reset/single word, model-checked stream scenarios.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] stall_cnt;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .beat_cnt    (beat_cnt),
    .stall_cnt   (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source FIFO contents and reference model of the adapter.
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int n_buf = 0;
  int infl_m = 0;
  int beats_m = 0;
  int stalls_m = 0;
  int rcv = 0;

  typedef struct {
    logic       rst;
    logic       gate;
    logic       rdy;
    logic       e_rd_en;
    logic       e_valid;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] exp_stat(input int v);
`ifdef FIFO_RD_STATS_EN
    return CW'(v);
`else
    return (v >= 0) ? '0 : '0;
`endif
  endfunction

  task automatic step(input logic rst, input logic gate, input logic rdy, input bit use_model,
                      output logic s_rd_en, output logic s_valid, output logic [DW-1:0] s_data);
    int e_used;
    logic e_valid;
    logic e_rd_en;
    logic [DW-1:0] dummy;
    @(negedge rd_clk);
    rd_rst     = rst;
    m_ready    = rdy;
    fifo_empty = (src_q.size() == 0) || gate;
    #1;
    s_rd_en = fifo_rd_en;
    s_valid = m_valid;
    s_data  = m_data;
    e_used  = n_buf + infl_m;
    e_valid = (n_buf > 0);
    e_rd_en = !rst && !fifo_empty && (e_used < 2 || (e_used == 2 && e_valid && rdy));
    if (use_model) begin
      check("rd_en", 32'(fifo_rd_en), 32'(e_rd_en));
      check("m_valid", 32'(m_valid), 32'(e_valid));
      if (e_valid && exp_q.size() > 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
      check("beat_cnt", 32'(beat_cnt), 32'(exp_stat(beats_m)));
      check("stall_cnt", 32'(stall_cnt), 32'(exp_stat(stalls_m)));
      check("rd_on_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
    end
    if (!rst && m_valid && rdy) rcv++;
    if (rst) begin
      n_buf = 0;
      infl_m = 0;
      exp_q.delete();
      beats_m = 0;
      stalls_m = 0;
    end else begin
      if (e_valid && rdy) begin
        n_buf--;
        dummy = exp_q.pop_front();
        beats_m++;
      end else if (e_valid) begin
        stalls_m++;
      end
      n_buf += infl_m;
      infl_m = e_rd_en ? 1 : 0;
      if (e_rd_en) exp_q.push_back(src_q[0]);
    end
    @(posedge rd_clk);
    #1;
    if (s_rd_en && src_q.size() > 0) fifo_rd_data = src_q.pop_front();
  endtask

  initial begin
    logic r, v;
    logic [DW-1:0] d;
    logic [DW-1:0] held;
    int budget;
    int bubbles;
    bit started;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset with a non-empty FIFO, then a single word.
    src_q.push_back(8'hA5);
    step(1'b1, 1'b0, 1'b1, 1'b0, r, v, d);
    rcv = 0;
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst, vecs[i].gate, vecs[i].rdy, 1'b0, r, v, d);
      check($sformatf("vec%0d_rd_en", i), 32'(r), 32'(vecs[i].e_rd_en));
      check($sformatf("vec%0d_valid", i), 32'(v), 32'(vecs[i].e_valid));
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].e_data));
    end
    check("single_beats", 32'(rcv), 32'd1);

    // Streaming 0x00..0x0F with ready held high.
    step(1'b1, 1'b0, 1'b1, 1'b0, r, v, d);
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
    rcv = 0;
    bubbles = 0;
    started = 1'b0;
    budget = 100;
    while (rcv < 16 && budget > 0) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
      if (v) started = 1'b1;
      else if (started) bubbles++;
      budget--;
    end
    check("stream_beats", 32'(rcv), 32'd16);
    check("stream_bubbles", 32'(bubbles), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
    check("stream_beat_cnt", 32'(beat_cnt), 32'(exp_stat(16)));

    // Backpressure: 0x10..0x17, five stalled cycles mid-stream.
    step(1'b1, 1'b0, 1'b1, 1'b0, r, v, d);
    for (int i = 0; i < 8; i++) src_q.push_back(DW'(8'h10 + i));
    rcv = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
    held = '0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, r, v, d);
      if (i == 0) held = d;
      check("bp_valid", 32'(v), 32'd1);
      check("bp_data_stable", 32'(d), 32'(held));
    end
    check("bp_rd_en_full", 32'(r), 32'd0);
    budget = 50;
    while (rcv < 8 && budget > 0) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
      budget--;
    end
    check("bp_beats", 32'(rcv), 32'd8);
    check("bp_stall_cnt", 32'(stall_cnt), 32'(exp_stat(5)));

    // Reset while the buffer is full, then resume.
    step(1'b1, 1'b0, 1'b1, 1'b0, r, v, d);
    for (int i = 0; i < 16; i++) src_q.push_back(DW'(8'h20 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, r, v, d);
    check("mid_full_valid", 32'(v), 32'd1);
    check("mid_full_rd_en", 32'(r), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, r, v, d);
    check("mid_rst_rd_en", 32'(r), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
    check("mid_after_valid", 32'(v), 32'd0);
    rcv = 0;
    budget = 100;
    while ((src_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, r, v, d);
      budget--;
    end
    check("mid_drained", 32'(exp_q.size() + src_q.size()), 32'd0);
    check("mid_resumed", 32'(rcv > 0), 32'd1);

    // Random empty/ready, 1000 words.
    step(1'b1, 1'b0, 1'b1, 1'b0, r, v, d);
    for (int i = 0; i < 1000; i++) src_q.push_back(DW'($urandom));
    rcv = 0;
    budget = 20000;
    while (rcv < 1000 && budget > 0) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, r, v, d);
      budget--;
    end
    check("rand_beats", 32'(rcv), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
